// File: rtl/multi_adder_display.sv
// Operand-accumulator core: touchscreen-loaded operand registers summed one per cycle,
// results on LCD slots and LEDs. Optional subtract mode is enabled by MULTI_ADDER_SUB_EN.
module multi_adder_display #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NUM_OPS   = 4,
    parameter int unsigned DISP_BASE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  input_sel,
    input  logic        sw_cin,
`ifdef MULTI_ADDER_SUB_EN
    input  logic        sw_sub,
`endif
    input  logic        input_valid,
    input  logic [31:0] input_value,
    input  logic [5:0]  display_number,
    output logic        display_valid,
    output logic [39:0] display_name,
    output logic [31:0] display_value,
    output logic        led_cout,
    output logic        led_ovf,
    output logic        led_busy
);

    localparam int unsigned KW = $clog2(NUM_OPS);
    localparam int unsigned SW = WIDTH + 1;
    localparam logic [31:0] OperTxt  = "OPER";
    localparam logic [39:0] ResulTxt = "RESUL";
    localparam logic [39:0] StatsTxt = "STATS";

    typedef enum logic {StIdle, StAccum} state_t;

    state_t           state;
    logic [WIDTH-1:0] op [NUM_OPS];
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] result;
    logic [KW-1:0]    k;
    logic             cflag, vflag;
    logic             cin_prev, cin_lat;
    logic             sub_prev, sub_lat, sub_now;
    logic             first;

    logic             load, start, is_first, last, step_cin, step_ovf;
    logic [WIDTH-1:0] operand;
    logic [SW-1:0]    sum;

`ifdef MULTI_ADDER_SUB_EN
    assign sub_now = sw_sub;
`else
    assign sub_now = 1'b0;
`endif

    assign load  = input_valid && (32'(input_sel) < NUM_OPS);
    assign start = load || (sw_cin != cin_prev) || (sub_now != sub_prev) || first;

    assign led_busy = (state == StAccum);

    // Subtraction after op0 is acc + ~op[k] + 1; cin only enters on the first step.
    always_comb begin
        is_first = (k == '0);
        last     = (k == KW'(NUM_OPS - 1));
        operand  = (sub_lat && !is_first) ? ~op[k] : op[k];
        step_cin = is_first ? cin_lat : sub_lat;
        sum      = {1'b0, acc} + {1'b0, operand} + SW'(step_cin);
        step_ovf = (acc[WIDTH-1] == operand[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StIdle;
            acc      <= '0;
            result   <= '0;
            k        <= '0;
            cflag    <= 1'b0;
            vflag    <= 1'b0;
            cin_prev <= 1'b0;
            cin_lat  <= 1'b0;
            sub_prev <= 1'b0;
            sub_lat  <= 1'b0;
            first    <= 1'b1;
            led_cout <= 1'b0;
            led_ovf  <= 1'b0;
            for (int unsigned i = 0; i < NUM_OPS; i++) op[i] <= '0;
        end else begin
            first    <= 1'b0;
            cin_prev <= sw_cin;
            sub_prev <= sub_now;
            for (int unsigned i = 0; i < NUM_OPS; i++) begin
                if (load && (32'(input_sel) == i)) op[i] <= input_value[WIDTH-1:0];
            end
            // A restart request wins over completion, so an aborted sum never lands.
            if (start) begin
                state   <= StAccum;
                k       <= '0;
                acc     <= '0;
                cflag   <= 1'b0;
                vflag   <= 1'b0;
                cin_lat <= sw_cin;
                sub_lat <= sub_now;
            end else if (state == StAccum) begin
                acc   <= sum[WIDTH-1:0];
                cflag <= cflag | sum[WIDTH];
                vflag <= vflag | step_ovf;
                k     <= k + 1'b1;
                if (last) begin
                    result   <= sum[WIDTH-1:0];
                    led_cout <= cflag | sum[WIDTH];
                    led_ovf  <= vflag | step_ovf;
                    k        <= '0;
                    state    <= StIdle;
                end
            end
        end
    end

    logic        disp_valid_d;
    logic [39:0] disp_name_d;
    logic [31:0] disp_value_d;

    always_comb begin
        disp_valid_d = 1'b0;
        disp_name_d  = '0;
        disp_value_d = '0;
        for (int unsigned i = 0; i < NUM_OPS; i++) begin
            if (display_number == 6'(DISP_BASE + i)) begin
                disp_valid_d = 1'b1;
                disp_name_d  = {OperTxt, 8'(8'h30 + i)};
                disp_value_d = 32'(op[i]);
            end
        end
        if (display_number == 6'(DISP_BASE + NUM_OPS)) begin
            disp_valid_d = 1'b1;
            disp_name_d  = ResulTxt;
            disp_value_d = 32'(result);
        end
        if (display_number == 6'(DISP_BASE + NUM_OPS + 1)) begin
            disp_valid_d = 1'b1;
            disp_name_d  = StatsTxt;
            disp_value_d = {27'd0, sub_lat, led_busy, led_cout, led_ovf, cin_lat};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            display_valid <= 1'b0;
            display_name  <= '0;
            display_value <= '0;
        end else begin
            display_valid <= disp_valid_d;
            display_name  <= disp_name_d;
            display_value <= disp_value_d;
        end
    end

endmodule

// File: tb/tb_multi_adder_display.sv
// Directed bench for multi_adder_display with default parameters (WIDTH 32, NUM_OPS 4,
// DISP_BASE 4); expected values are hand-computed constants.
module tb_multi_adder_display;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  input_sel;
    logic        sw_cin;
    logic        input_valid;
    logic [31:0] input_value;
    logic [5:0]  display_number;
    logic        display_valid;
    logic [39:0] display_name;
    logic [31:0] display_value;
    logic        led_cout, led_ovf, led_busy;

    int checks   = 0;
    int failures = 0;
    int n;

    localparam logic [39:0] NameResul = 40'h524553554C;
    localparam logic [39:0] NameStats = 40'h5354415453;

    always #50 clk = ~clk;

    multi_adder_display dut (
        .clk            (clk),
        .reset          (reset),
        .input_sel      (input_sel),
        .sw_cin         (sw_cin),
        .input_valid    (input_valid),
        .input_value    (input_value),
        .display_number (display_number),
        .display_valid  (display_valid),
        .display_name   (display_name),
        .display_value  (display_value),
        .led_cout       (led_cout),
        .led_ovf        (led_ovf),
        .led_busy       (led_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] sel, input logic [31:0] val);
        input_sel   = sel;
        input_value = val;
        input_valid = 1'b1;
        tick();
        input_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (led_busy && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic read_slot(input logic [5:0] num);
        display_number = num;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [39:0] exp_name;
        logic [31:0] exp_ops [4];
        exp_ops = '{32'h3, 32'h5, 32'h100, 32'h0};
        reset = 1'b1; sw_cin = 1'b0; input_valid = 1'b0; input_sel = '0;
        input_value = '0; display_number = '0;
        repeat (3) tick();
        check("rst_busy", led_busy, 0);
        check("rst_cout", led_cout, 0);
        check("rst_ovf", led_ovf, 0);
        check("rst_dvalid", display_valid, 0);
        check("rst_dname", display_name, 0);
        check("rst_dvalue", display_value, 0);

        // Auto-start after reset, cin=0
        reset = 1'b0;
        tick();
        check("auto0_busy", led_busy, 1);
        wait_idle(n);
        check("auto0_busy_len", n, 4);
        read_slot(6'd8);
        check("auto0_name", display_name, NameResul);
        check("auto0_result", display_value, 0);
        check("auto0_cout", led_cout, 0);
        check("auto0_ovf", led_ovf, 0);

        // Auto-start after reset, cin=1
        reset = 1'b1; sw_cin = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        wait_idle(n);
        check("auto1_busy_len", n, 4);
        read_slot(6'd8);
        check("auto1_result", display_value, 1);
        read_slot(6'd9);
        check("auto1_stats_name", display_name, NameStats);
        check("auto1_stats", display_value, 1);

        // Changing sw_cin restarts
        sw_cin = 1'b0;
        tick();
        check("cin_change_busy", led_busy, 1);
        wait_idle(n);
        check("cin_change_len", n, 4);

        // Basic sum
        load(3'd0, 32'h10); load(3'd1, 32'h20); load(3'd2, 32'h30); load(3'd3, 32'h40);
        wait_idle(n);
        check("basic_busy_len", n, 4);
        read_slot(6'd8);
        check("basic_result", display_value, 32'hA0);
        check("basic_cout", led_cout, 0);
        check("basic_ovf", led_ovf, 0);

        // Carry out
        load(3'd0, 32'hFFFF_FFFF); load(3'd1, 32'h1); load(3'd2, 32'h0); load(3'd3, 32'h0);
        wait_idle(n);
        read_slot(6'd8);
        check("carry_result", display_value, 0);
        check("carry_cout", led_cout, 1);
        check("carry_ovf", led_ovf, 0);

        // Signed overflow
        load(3'd0, 32'h7FFF_FFFF);
        wait_idle(n);
        read_slot(6'd8);
        check("ovf_result", display_value, 32'h8000_0000);
        check("ovf_cout", led_cout, 0);
        check("ovf_ovf", led_ovf, 1);

        // Restart mid-accumulation
        load(3'd0, 32'h3); load(3'd1, 32'h4);
        wait_idle(n);
        read_slot(6'd8);
        check("pre_restart_result", display_value, 32'h7);
        load(3'd2, 32'h100);
        tick(); tick();
        load(3'd1, 32'h5);
        check("restart_busy", led_busy, 1);
        check("restart_no_partial", display_value, 32'h7);
        wait_idle(n);
        check("restart_busy_len", n, 4);
        tick();
        check("restart_result", display_value, 32'h108);

        // Out-of-range select is ignored
        load(3'd6, 32'hDEAD_BEEF);
        check("ignored_busy", led_busy, 0);
        for (int i = 0; i < 4; i++) begin
            read_slot(6'(4 + i));
            exp_name = {32'h4F504552, 8'(8'h30 + i)};
            check($sformatf("oper%0d_valid", i), display_valid, 1);
            check($sformatf("oper%0d_name", i), display_name, exp_name);
            check($sformatf("oper%0d_value", i), display_value, exp_ops[i]);
        end
        read_slot(6'd9);
        check("stats_valid", display_valid, 1);
        check("stats_value", display_value, 0);
        read_slot(6'd3);
        check("slot3_valid", display_valid, 0);
        check("slot3_name", display_name, 0);
        check("slot3_value", display_value, 0);
        read_slot(6'd10);
        check("slot10_valid", display_valid, 0);
        check("slot10_value", display_value, 0);

        // One-cycle display latency
        read_slot(6'd4);
        display_number = 6'd10;
        #10;
        check("lat_hold_valid", display_valid, 1);
        tick();
        check("lat_new_valid", display_valid, 0);

        // Reset during accumulation
        load(3'd0, 32'h1);
        tick();
        check("mid_busy", led_busy, 1);
        reset = 1'b1;
        tick();
        check("mid_rst_busy", led_busy, 0);
        check("mid_rst_cout", led_cout, 0);
        check("mid_rst_ovf", led_ovf, 0);
        check("mid_rst_dvalid", display_valid, 0);
        check("mid_rst_dvalue", display_value, 0);
        reset = 1'b0;
        tick();
        check("mid_auto_busy", led_busy, 1);
        wait_idle(n);
        read_slot(6'd4);
        check("mid_op0_cleared", display_value, 0);
        read_slot(6'd8);
        check("mid_result", display_value, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
